// File: rtl/y_log_pkg.sv
// Shared constants for the Y event logger.
// Defaults for FIFO depth, timestamp width and pointer width.
package y_log_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int TS_W_DEF  = 8;
  localparam int PTR_W_DEF = $clog2(DEPTH_DEF);

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/y_event_logger_if.sv
// Push/pop bundle between the logger core and its timestamp FIFO.
// The master drives requests, the slave returns head data and status.
interface y_event_logger_if #(
  parameter int TS_W = 8
) ();

  logic            push;
  logic [TS_W-1:0] wdata;
  logic            pop;
  logic            clr;
  logic [TS_W-1:0] rdata;
  logic            empty;
  logic            full;
  logic            ovf_try;

  modport master (
    output push, wdata, pop, clr,
    input  rdata, empty, full, ovf_try
  );

  modport slave (
    input  push, wdata, pop, clr,
    output rdata, empty, full, ovf_try
  );

endinterface

// File: rtl/ts_fifo.sv
// Timestamp FIFO, first-word-fall-through, falling-edge clocked.
// A push into a full FIFO is dropped unless a pop frees the slot.
module ts_fifo
  import y_log_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int TS_W  = TS_W_DEF
) (
  input logic              i_clk,
  input logic              i_rst_n,
  y_event_logger_if.slave  f
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [TS_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_cnt;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == CNT_W'(DEPTH));
  assign w_do_pop  = f.pop & ~w_empty;
  assign w_do_push = f.push & (~w_full | w_do_pop);

  assign f.empty   = w_empty;
  assign f.full    = w_full;
  assign f.rdata   = r_mem[r_rptr];
  assign f.ovf_try = f.push & w_full & ~w_do_pop;

  // Storage write; contents need no reset, occupancy guards reads.
  always_ff @(negedge i_clk) begin
    if (!f.clr && w_do_push) begin
      r_mem[r_wptr] <= f.wdata;
    end
  end

  // Pointers wrap naturally modulo DEPTH; occupancy tracks fill level.
  always_ff @(negedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (f.clr) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      r_cnt <= r_cnt
             + CNT_W'(w_do_push)
             - CNT_W'(w_do_pop);
    end
  end

endmodule

// File: rtl/y_event_logger.sv
// Timestamps rising edges of the upstream detector output Y.
// Holds edge detect, timestamp, event count and overflow flag.
module y_event_logger
  import y_log_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int TS_W  = TS_W_DEF
) (
  input  logic            CLK,
  input  logic            RES,
  input  logic            Y_IN,
  input  logic            CLR,
  input  logic            RD_EN,
  output logic [TS_W-1:0] RD_DATA,
  output logic            EMPTY,
  output logic            FULL,
  output logic            OVF,
  output logic [TS_W-1:0] EVT_CNT
);

  logic [TS_W-1:0] r_ts;
  logic [TS_W-1:0] r_evt_cnt;
  logic            r_y_d;
  logic            r_ovf;
  logic            w_evt;

  y_event_logger_if #(.TS_W(TS_W)) u_if ();

  assign w_evt = Y_IN & ~r_y_d;

  assign u_if.push  = w_evt;
  assign u_if.wdata = r_ts;
  assign u_if.pop   = RD_EN;
  assign u_if.clr   = CLR;

  ts_fifo #(
    .DEPTH (DEPTH),
    .TS_W  (TS_W)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (RES),
    .f       (u_if.slave)
  );

  assign RD_DATA = u_if.rdata;
  assign EMPTY   = u_if.empty;
  assign FULL    = u_if.full;
  assign OVF     = r_ovf;
  assign EVT_CNT = r_evt_cnt;

  // Timestamp, edge detect, saturating count and sticky overflow.
  always_ff @(negedge CLK or negedge RES) begin
    if (!RES) begin
      r_ts      <= '0;
      r_y_d     <= 1'b0;
      r_evt_cnt <= '0;
      r_ovf     <= 1'b0;
    end else if (CLR) begin
      r_ts      <= '0;
      r_y_d     <= 1'b0;
      r_evt_cnt <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_ts  <= r_ts + 1'b1;
      r_y_d <= Y_IN;
      if (w_evt && (r_evt_cnt != '1)) begin
        r_evt_cnt <= r_evt_cnt + 1'b1;
      end
      if (u_if.ovf_try) begin
        r_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_y_event_logger.sv
// Directed bench for y_event_logger with a timestamp scoreboard.
// Inputs change 1 time unit after each falling edge.
module tb_y_event_logger;

  localparam int DEPTH = 4;

  logic       CLK;
  logic       RES;
  logic       Y_IN;
  logic       CLR;
  logic       RD_EN;
  logic [7:0] RD_DATA;
  logic       EMPTY;
  logic       FULL;
  logic       OVF;
  logic [7:0] EVT_CNT;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] q[$];
  logic [7:0] m_ts;
  logic [7:0] m_cnt;
  logic       m_yd;
  logic       m_ovf;

  y_event_logger dut (
    .CLK     (CLK),
    .RES     (RES),
    .Y_IN    (Y_IN),
    .CLR     (CLR),
    .RD_EN   (RD_EN),
    .RD_DATA (RD_DATA),
    .EMPTY   (EMPTY),
    .FULL    (FULL),
    .OVF     (OVF),
    .EVT_CNT (EVT_CNT)
  );

  initial CLK = 1'b1;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_ts  = 8'd0;
    m_cnt = 8'd0;
    m_yd  = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic check_state();
    chk("empty", 32'(EMPTY), 32'(q.size() == 0));
    chk("full", 32'(FULL), 32'(q.size() == DEPTH));
    chk("ovf", 32'(OVF), 32'(m_ovf));
    chk("evt_cnt", 32'(EVT_CNT), 32'(m_cnt));
    if (q.size() != 0) chk("head", 32'(RD_DATA), 32'(q[0]));
  endtask

  task automatic edge_();
    bit evt;
    bit pop;
    evt = Y_IN && !m_yd;
    if (CLR) begin
      model_clear();
    end else begin
      pop = RD_EN && (q.size() != 0);
      if (pop) begin
        chk("pop", 32'(RD_DATA), 32'(q[0]));
        void'(q.pop_front());
      end
      if (evt) begin
        if (q.size() < DEPTH) q.push_back(m_ts);
        else m_ovf = 1'b1;
        if (m_cnt != 8'hff) m_cnt++;
      end
      m_yd = Y_IN;
      m_ts++;
    end
    @(negedge CLK);
    #1;
    check_state();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) edge_();
  endtask

  task automatic clear();
    CLR = 1'b1;
    edge_();
    CLR = 1'b0;
  endtask

  task automatic pulse();
    Y_IN = 1'b1;
    edge_();
    Y_IN = 1'b0;
    edge_();
  endtask

  task automatic read_one(input logic [7:0] exp);
    chk("read_dir", 32'(RD_DATA), 32'(exp));
    RD_EN = 1'b1;
    edge_();
    RD_EN = 1'b0;
  endtask

  initial begin
    logic [7:0] head0;
    RES   = 1'b0;
    Y_IN  = 1'b0;
    CLR   = 1'b0;
    RD_EN = 1'b0;
    model_clear();
    #2;
    chk("rst_empty", 32'(EMPTY), 32'd1);
    chk("rst_full", 32'(FULL), 32'd0);
    chk("rst_ovf", 32'(OVF), 32'd0);
    chk("rst_cnt", 32'(EVT_CNT), 32'd0);
    RES = 1'b1;

    idle(10);
    chk("idle_empty", 32'(EMPTY), 32'd1);
    chk("idle_cnt", 32'(EVT_CNT), 32'd0);

    clear();
    idle(5);
    Y_IN = 1'b1;
    idle(4);
    Y_IN = 1'b0;
    idle(1);
    chk("held_cnt", 32'(EVT_CNT), 32'd1);
    chk("held_data", 32'(RD_DATA), 32'd5);
    chk("held_size", 32'(q.size()), 32'd1);
    read_one(8'd5);
    chk("held_drain", 32'(EMPTY), 32'd1);

    RD_EN = 1'b1;
    idle(2);
    RD_EN = 1'b0;

    clear();
    for (int i = 0; i <= 10; i++) begin
      Y_IN = (i >= 2) && (i % 2 == 0);
      edge_();
    end
    Y_IN = 1'b0;
    chk("ovf_full", 32'(FULL), 32'd1);
    chk("ovf_flag", 32'(OVF), 32'd1);
    read_one(8'd2);
    read_one(8'd4);
    read_one(8'd6);
    read_one(8'd8);
    chk("ovf_drain", 32'(EMPTY), 32'd1);
    chk("ovf_sticky", 32'(OVF), 32'd1);

    clear();
    repeat (4) pulse();
    chk("sim_full0", 32'(FULL), 32'd1);
    head0 = RD_DATA;
    Y_IN  = 1'b1;
    RD_EN = 1'b1;
    edge_();
    Y_IN  = 1'b0;
    RD_EN = 1'b0;
    chk("sim_full1", 32'(FULL), 32'd1);
    chk("sim_ovf", 32'(OVF), 32'd0);
    chk("sim_adv", 32'(RD_DATA), 32'(head0 + 8'd2));
    edge_();

    Y_IN  = 1'b1;
    RD_EN = 1'b1;
    CLR   = 1'b1;
    edge_();
    CLR   = 1'b0;
    RD_EN = 1'b0;
    Y_IN  = 1'b0;
    chk("clr_win", 32'(EMPTY), 32'd1);
    chk("clr_cnt", 32'(EVT_CNT), 32'd0);

    clear();
    idle(254);
    Y_IN = 1'b1;
    edge_();
    Y_IN = 1'b0;
    idle(2);
    Y_IN = 1'b1;
    edge_();
    Y_IN = 1'b0;
    edge_();
    read_one(8'd254);
    read_one(8'd1);
    repeat (300) pulse();
    chk("sat_cnt", 32'(EVT_CNT), 32'd255);
    chk("sat_ovf", 32'(OVF), 32'd1);

    clear();
    repeat (3) pulse();
    chk("pre_rst", 32'(q.size()), 32'd3);
    RES = 1'b0;
    #1;
    model_clear();
    chk("async_empty", 32'(EMPTY), 32'd1);
    chk("async_cnt", 32'(EVT_CNT), 32'd0);
    chk("async_full", 32'(FULL), 32'd0);
    #1;
    RES  = 1'b1;
    Y_IN = 1'b1;
    edge_();
    Y_IN = 1'b0;
    chk("post_cnt", 32'(EVT_CNT), 32'd1);
    chk("post_data", 32'(RD_DATA), 32'd0);
    edge_();

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
